// File: rtl/dmem_ctrl_if.sv
// Datapath <-> data-memory controller bus: request fields one way, completion and load data back.
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        fault;

    modport master (output req, we, funct3, addr, wdata,
                    input  rdata, stall, done, fault);
    modport slave  (input  req, we, funct3, addr, wdata,
                    output rdata, stall, done, fault);
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: word RAM with configurable latency, byte-lane steering for stores,
// load extension, and fault detection for misaligned or illegal-width accesses.
module dmem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    dmem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nxt;
    logic [3:0]    cnt;
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [31:0]   wd_q;
    logic [31:0]   rd_q;
    logic          flt_q;
    logic [31:0]   mem [DEPTH];

    logic          req_bad;
    logic          acc;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [7:0]    bsel;
    logic [15:0]   hsel;
    logic [31:0]   ext;

    // Address bits above the RAM index are intentionally ignored (addresses wrap).
    logic unused_addr;
    assign unused_addr = ^bus.addr[31:AW+2];

    always_comb begin
        req_bad = 1'b1;
        case (bus.funct3)
            3'b000, 3'b100: req_bad = 1'b0;
            3'b001, 3'b101: req_bad = bus.addr[0];
            3'b010:         req_bad = |bus.addr[1:0];
            default:        req_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req) state_nxt = req_bad ? DONE : BUSY;
            BUSY:    if (cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            idx_q <= '0;
            off_q <= 2'd0;
            we_q  <= 1'b0;
            f3_q  <= 3'd0;
            wd_q  <= 32'd0;
            flt_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (bus.req) begin
                    if (req_bad) begin
                        flt_q <= 1'b1;
                    end else begin
                        idx_q <= bus.addr[AW+1:2];
                        off_q <= bus.addr[1:0];
                        we_q  <= bus.we;
                        f3_q  <= bus.funct3;
                        wd_q  <= bus.wdata;
                        cnt   <= 4'(WAIT_CYCLES);
                    end
                end
                BUSY:    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                DONE:    flt_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign acc = (state == BUSY) && (cnt == 4'd0);

    // Only legal widths are ever latched, so f3_q[1:0] is 00 (byte), 01 (half) or 10 (word).
    always_comb begin
        be    = 4'b1111;
        wlane = wd_q;
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << off_q;
                wlane = {4{wd_q[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << {off_q[1], 1'b0};
                wlane = {2{wd_q[15:0]}};
            end
            default: ;
        endcase
    end

    // RAM is not reset; access happens on the final BUSY edge only.
    always_ff @(posedge clk) begin
        if (acc) begin
            if (we_q) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) mem[idx_q][8*i +: 8] <= wlane[8*i +: 8];
            end else begin
                rd_q <= mem[idx_q];
            end
        end
    end

    always_comb begin
        bsel = rd_q[8*off_q +: 8];
        hsel = off_q[1] ? rd_q[31:16] : rd_q[15:0];
        case (f3_q)
            3'b000:  ext = {{24{bsel[7]}}, bsel};
            3'b100:  ext = {24'd0, bsel};
            3'b001:  ext = {{16{hsel[15]}}, hsel};
            3'b101:  ext = {16'd0, hsel};
            default: ext = rd_q;
        endcase
    end

    assign bus.stall = ((state == IDLE) && bus.req) || (state == BUSY);
    assign bus.done  = (state == DONE);
    assign bus.fault = (state == DONE) && flt_q;
    assign bus.rdata = ((state == DONE) && !flt_q && !we_q) ? ext : 32'd0;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: two instances (WAIT_CYCLES=1 and 0) driven through their buses.
module tb_dmem_ctrl;
    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101, F_X = 3'b011;

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_flt;
        logic [4:0]  lat;
        logic        scr;
    } op_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          stalls;
        logic        dn_stall;
    } obs_t;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;
    op_t  exp_q[$];

    dmem_ctrl_if bus_w1();
    dmem_ctrl_if bus_w0();

    dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(1)) u_w1 (.clk(clk), .reset(reset), .bus(bus_w1));
    dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (.clk(clk), .reset(reset), .bus(bus_w0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic op_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] rd, input logic flt,
                               input int lat, input bit scr);
        op_t o;
        o.we = we; o.f3 = f3; o.a = a; o.d = d;
        o.exp_rd = rd; o.exp_flt = flt; o.lat = 5'(lat); o.scr = scr;
        return o;
    endfunction

    task automatic drv(input int wc, input logic rq, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
        if (wc == 1) begin
            bus_w1.req = rq; bus_w1.we = we; bus_w1.funct3 = f3; bus_w1.addr = a; bus_w1.wdata = d;
        end else begin
            bus_w0.req = rq; bus_w0.we = we; bus_w0.funct3 = f3; bus_w0.addr = a; bus_w0.wdata = d;
        end
    endtask

    task automatic smp(input int wc, output logic st, output logic dn, output logic flt,
                       output logic [31:0] rd);
        if (wc == 1) begin
            st = bus_w1.stall; dn = bus_w1.done; flt = bus_w1.fault; rd = bus_w1.rdata;
        end else begin
            st = bus_w0.stall; dn = bus_w0.done; flt = bus_w0.fault; rd = bus_w0.rdata;
        end
    endtask

    // Issue one access in the cycle after the previous one's DONE; cycle 0 is the request cycle.
    task automatic access(input int wc, input op_t op, output obs_t o);
        logic st, dn, flt;
        logic [31:0] rd;
        o.rdata = 32'd0; o.fault = 1'b0; o.lat = -1; o.stalls = 0; o.dn_stall = 1'b0;
        @(posedge clk); #1;
        drv(wc, 1'b1, op.we, op.f3, op.a, op.d);
        for (int n = 0; n < 40; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                if (n == 1 && op.scr) drv(wc, 1'b1, op.we, F_X, op.a ^ 32'hFC, ~op.d);
            end
            #1;
            smp(wc, st, dn, flt, rd);
            if (dn === 1'b1) begin
                o.rdata = rd; o.fault = flt; o.lat = n; o.dn_stall = st;
                drv(wc, 1'b0, 1'b0, F_W, 32'd0, 32'd0);
                return;
            end
            if (st === 1'b1) o.stalls++;
        end
        drv(wc, 1'b0, 1'b0, F_W, 32'd0, 32'd0);
    endtask

    task automatic test_reset;
        logic st, dn, flt;
        logic [31:0] rd;
        reset = 1'b1;
        drv(1, 1'b0, 1'b0, F_W, 32'd0, 32'd0);
        drv(0, 1'b0, 1'b0, F_W, 32'd0, 32'd0);
        #12;
        smp(1, st, dn, flt, rd);
        nvec++;
        if ({st, dn, flt, rd} !== 35'd0) begin
            nerr++;
            $display("FAIL reset_state stall=%b done=%b fault=%b rdata=%h want all 0", st, dn, flt, rd);
        end
        drv(1, 1'b1, 1'b0, F_W, 32'd0, 32'd0);
        #1;
        smp(1, st, dn, flt, rd);
        nvec++;
        if (st !== 1'b1 || dn !== 1'b0) begin
            nerr++;
            $display("FAIL reset_stall_follows_req stall=%b done=%b want 1 0", st, dn);
        end
        drv(1, 1'b0, 1'b0, F_W, 32'd0, 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word;
        op_t ops[$];
        op_t e;
        obs_t o;
        ops.push_back(mk(1'b1, F_W, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3, 1'b1));
        ops.push_back(mk(1'b0, F_W, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1'b1));
        foreach (ops[i]) begin
            exp_q.push_back(ops[i]);
            access(1, ops[i], o);
            e = exp_q.pop_front();
            nvec++;
            if (o.rdata !== e.exp_rd) begin
                nerr++; $display("FAIL word[%0d] rdata got %h want %h", i, o.rdata, e.exp_rd);
            end
            nvec++;
            if (o.fault !== e.exp_flt) begin
                nerr++; $display("FAIL word[%0d] fault got %b want %b", i, o.fault, e.exp_flt);
            end
            nvec++;
            if (o.lat != int'(e.lat) || o.stalls != int'(e.lat) || o.dn_stall !== 1'b0) begin
                nerr++; $display("FAIL word[%0d] timing done_cyc=%0d stalls=%0d want %0d", i, o.lat, o.stalls, e.lat);
            end
        end
    endtask

    task automatic test_byte_half;
        op_t ops[$];
        op_t e;
        obs_t o;
        ops.push_back(mk(1'b1, F_W,  32'h0, 32'h0,        32'h0,        1'b0, 3, 1'b0));
        ops.push_back(mk(1'b1, F_B,  32'h3, 32'h00000080, 32'h0,        1'b0, 3, 1'b0));
        ops.push_back(mk(1'b0, F_B,  32'h3, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1'b0));
        ops.push_back(mk(1'b0, F_BU, 32'h3, 32'h0,        32'h00000080, 1'b0, 3, 1'b0));
        ops.push_back(mk(1'b0, F_W,  32'h0, 32'h0,        32'h80000000, 1'b0, 3, 1'b0));
        ops.push_back(mk(1'b1, F_W,  32'h0, 32'h11223344, 32'h0,        1'b0, 3, 1'b0));
        ops.push_back(mk(1'b1, F_H,  32'h2, 32'h0000BEEF, 32'h0,        1'b0, 3, 1'b0));
        ops.push_back(mk(1'b0, F_W,  32'h0, 32'h0,        32'hBEEF3344, 1'b0, 3, 1'b0));
        ops.push_back(mk(1'b0, F_H,  32'h2, 32'h0,        32'hFFFFBEEF, 1'b0, 3, 1'b0));
        ops.push_back(mk(1'b0, F_HU, 32'h2, 32'h0,        32'h0000BEEF, 1'b0, 3, 1'b0));
        ops.push_back(mk(1'b0, F_B,  32'h1, 32'h0,        32'h00000033, 1'b0, 3, 1'b0));
        ops.push_back(mk(1'b0, F_H,  32'h0, 32'h0,        32'h00003344, 1'b0, 3, 1'b0));
        foreach (ops[i]) begin
            exp_q.push_back(ops[i]);
            access(1, ops[i], o);
            e = exp_q.pop_front();
            nvec++;
            if (o.rdata !== e.exp_rd) begin
                nerr++; $display("FAIL lanes[%0d] rdata got %h want %h", i, o.rdata, e.exp_rd);
            end
            nvec++;
            if (o.fault !== e.exp_flt || o.lat != int'(e.lat) || o.stalls != int'(e.lat)) begin
                nerr++; $display("FAIL lanes[%0d] fault=%b done_cyc=%0d stalls=%0d want %b %0d", i, o.fault, o.lat, o.stalls, e.exp_flt, e.lat);
            end
        end
    endtask

    task automatic test_fault;
        op_t ops[$];
        op_t e;
        obs_t o;
        ops.push_back(mk(1'b1, F_W,  32'h0, 32'hCAFEF00D, 32'h0,        1'b0, 3, 1'b0));
        ops.push_back(mk(1'b1, F_H,  32'h1, 32'h0000FFFF, 32'h0,        1'b1, 1, 1'b0));
        ops.push_back(mk(1'b0, F_W,  32'h6, 32'h0,        32'h0,        1'b1, 1, 1'b0));
        ops.push_back(mk(1'b1, F_X,  32'h0, 32'h0,        32'h0,        1'b1, 1, 1'b0));
        ops.push_back(mk(1'b1, F_W,  32'h2, 32'h0,        32'h0,        1'b1, 1, 1'b0));
        ops.push_back(mk(1'b0, F_HU, 32'h3, 32'h0,        32'h0,        1'b1, 1, 1'b0));
        ops.push_back(mk(1'b0, 3'b111, 32'h0, 32'h0,      32'h0,        1'b1, 1, 1'b0));
        ops.push_back(mk(1'b0, F_W,  32'h0, 32'h0,        32'hCAFEF00D, 1'b0, 3, 1'b0));
        foreach (ops[i]) begin
            exp_q.push_back(ops[i]);
            access(1, ops[i], o);
            e = exp_q.pop_front();
            nvec++;
            if (o.rdata !== e.exp_rd) begin
                nerr++; $display("FAIL fault[%0d] rdata got %h want %h", i, o.rdata, e.exp_rd);
            end
            nvec++;
            if (o.fault !== e.exp_flt) begin
                nerr++; $display("FAIL fault[%0d] fault got %b want %b", i, o.fault, e.exp_flt);
            end
            nvec++;
            if (o.lat != int'(e.lat) || o.stalls != int'(e.lat)) begin
                nerr++; $display("FAIL fault[%0d] timing done_cyc=%0d stalls=%0d want %0d", i, o.lat, o.stalls, e.lat);
            end
        end
    endtask

    task automatic test_back_to_back;
        op_t ops[$];
        op_t e;
        obs_t o;
        ops.push_back(mk(1'b1, F_W, 32'h1004, 32'h12345678, 32'h0,        1'b0, 2, 1'b0));
        ops.push_back(mk(1'b0, F_W, 32'h4,    32'h0,        32'h12345678, 1'b0, 2, 1'b0));
        ops.push_back(mk(1'b0, F_B, 32'h1007, 32'h0,        32'h00000012, 1'b0, 2, 1'b0));
        ops.push_back(mk(1'b1, F_B, 32'h2005, 32'h000000A5, 32'h0,        1'b0, 2, 1'b0));
        ops.push_back(mk(1'b0, F_W, 32'h4,    32'h0,        32'h1234A578, 1'b0, 2, 1'b0));
        ops.push_back(mk(1'b0, F_H, 32'h3,    32'h0,        32'h0,        1'b1, 1, 1'b0));
        ops.push_back(mk(1'b0, F_HU, 32'h6,   32'h0,        32'h00001234, 1'b0, 2, 1'b0));
        foreach (ops[i]) begin
            exp_q.push_back(ops[i]);
            access(0, ops[i], o);
            e = exp_q.pop_front();
            nvec++;
            if (o.rdata !== e.exp_rd) begin
                nerr++; $display("FAIL b2b[%0d] rdata got %h want %h", i, o.rdata, e.exp_rd);
            end
            nvec++;
            if (o.fault !== e.exp_flt || o.lat != int'(e.lat) || o.stalls != int'(e.lat) || o.dn_stall !== 1'b0) begin
                nerr++; $display("FAIL b2b[%0d] fault=%b done_cyc=%0d stalls=%0d want %b %0d", i, o.fault, o.lat, o.stalls, e.exp_flt, e.lat);
            end
        end
    endtask

    task automatic test_reset_midop;
        op_t e;
        op_t op;
        obs_t o;
        logic st, dn, flt;
        logic [31:0] rd;
        op = mk(1'b1, F_W, 32'h20, 32'hAAAAAAAA, 32'h0, 1'b0, 3, 1'b0);
        exp_q.push_back(op);
        access(1, op, o);
        e = exp_q.pop_front();
        nvec++;
        if (o.fault !== e.exp_flt || o.lat != int'(e.lat)) begin
            nerr++; $display("FAIL midreset_prestore fault=%b done_cyc=%0d want %b %0d", o.fault, o.lat, e.exp_flt, e.lat);
        end
        @(posedge clk); #1;
        drv(1, 1'b1, 1'b1, F_W, 32'h20, 32'h55555555);
        @(posedge clk); #1;
        smp(1, st, dn, flt, rd);
        nvec++;
        if (st !== 1'b1 || dn !== 1'b0) begin
            nerr++; $display("FAIL midreset_busy stall=%b done=%b want 1 0", st, dn);
        end
        reset = 1'b1;
        drv(1, 1'b0, 1'b0, F_W, 32'd0, 32'd0);
        #1;
        smp(1, st, dn, flt, rd);
        nvec++;
        if (st !== 1'b0 || dn !== 1'b0 || flt !== 1'b0) begin
            nerr++; $display("FAIL midreset_idle stall=%b done=%b fault=%b want 0 0 0", st, dn, flt);
        end
        @(posedge clk); #1;
        smp(1, st, dn, flt, rd);
        nvec++;
        if (dn !== 1'b0) begin
            nerr++; $display("FAIL midreset_no_done done=%b want 0", dn);
        end
        @(negedge clk);
        reset = 1'b0;
        op = mk(1'b0, F_W, 32'h20, 32'h0, 32'hAAAAAAAA, 1'b0, 3, 1'b0);
        exp_q.push_back(op);
        access(1, op, o);
        e = exp_q.pop_front();
        nvec++;
        if (o.rdata !== e.exp_rd) begin
            nerr++; $display("FAIL midreset_ram rdata got %h want %h", o.rdata, e.exp_rd);
        end
        nvec++;
        if (o.lat != int'(e.lat) || o.stalls != int'(e.lat)) begin
            nerr++; $display("FAIL midreset_ram_timing done_cyc=%0d stalls=%0d want %0d", o.lat, o.stalls, e.lat);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_word();
        test_byte_half();
        test_fault();
        test_back_to_back();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
